// File: rtl/ifu_pkg.sv
// Shared core definitions for the instruction fetch unit: widths, reset PC,
// canonical NOP encoding and the fetch state encoding.
package ifu_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding 32-bit fetch at a time, delivered
// to decode over valid/ready, with PC redirects that squash stale fetches.
module ifu
    import ifu_pkg::*;
#(
    parameter int XLEN = ifu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = ifu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    fetch_state_e    state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [XLEN-1:0] inst_pc_r, inst_pc_nxt_s;
    logic [XLEN-1:0] redirect_pc_al_s;
    logic [31:0]     inst_r, inst_nxt_s;
    logic            drop_r, drop_nxt_s;
    logic            inst_valid_r, inst_valid_nxt_s;
    logic            req_fire_s, inst_fire_s;
    logic            unused_redirect_lsb_s;

    assign redirect_pc_al_s      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];
    assign req_fire_s            = imem_req_valid & imem_req_ready;
    assign inst_fire_s           = inst_valid_r & inst_ready;

    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;

    // State register: all architectural fetch state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= REQ;
            pc_r         <= RESET_PC;
            drop_r       <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= {XLEN{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            drop_r       <= drop_nxt_s;
            inst_valid_r <= inst_valid_nxt_s;
            inst_r       <= inst_nxt_s;
            inst_pc_r    <= inst_pc_nxt_s;
        end
    end

    // Next-state logic; a redirect overrides any other PC update
    always_comb begin
        state_nxt_s      = state_r;
        drop_nxt_s       = drop_r;
        inst_valid_nxt_s = inst_valid_r;
        inst_nxt_s       = inst_r;
        inst_pc_nxt_s    = inst_pc_r;
        case (state_r)
            REQ: begin
                if (req_fire_s) begin
                    state_nxt_s = WAIT;
                    drop_nxt_s  = redirect_valid;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_r || redirect_valid) begin
                        state_nxt_s = REQ;
                        drop_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s      = OUT;
                        inst_nxt_s       = imem_rsp_data;
                        inst_pc_nxt_s    = pc_r;
                        inst_valid_nxt_s = 1'b1;
                    end
                end else if (redirect_valid) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            OUT: begin
                if (redirect_valid || inst_fire_s) begin
                    state_nxt_s      = REQ;
                    inst_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s      = REQ;
                drop_nxt_s       = 1'b0;
                inst_valid_nxt_s = 1'b0;
            end
        endcase

        if (redirect_valid) begin
            pc_nxt_s = redirect_pc_al_s;
        end else if ((state_r == OUT) && inst_fire_s) begin
            pc_nxt_s = pc_r + PC_STEP;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Request outputs; suppressed while reset is held
    always_comb begin
        imem_req_addr = pc_r;
        if (!rst && (state_r == REQ)) begin
            imem_req_valid = 1'b1;
        end else begin
            imem_req_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the fetch unit and memory.
module tb_ifu;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ifu #(.XLEN(64), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: abstract view of the fetch unit
    logic [63:0] m_pc, m_inst_pc;
    logic [31:0] m_inst;
    bit          m_busy, m_stale, m_have;
    // Memory model
    bit          mem_pending;
    int          mem_cnt;
    logic [63:0] mem_addr;
    int          mem_lat_max = 1;
    bit          spurious = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == RPC) return 32'h0050_0093;
        return a[31:0] ^ 32'h5A5A_0013 ^ {a[63:48], 16'h0000};
    endfunction

    // One clock cycle: drive memory response, advance model, compare after the edge
    task automatic cycle();
        bit          exp_rv, hs, n_busy, n_stale, n_have;
        logic [63:0] n_pc, n_ipc;
        logic [31:0] n_inst;
        if (mem_pending && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
        end else if (!mem_pending && spurious && $urandom_range(0, 5) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        exp_rv = !rst && !m_busy && !m_have;
        hs = exp_rv && imem_req_ready;
        n_busy = m_busy; n_stale = m_stale; n_have = m_have;
        n_pc = m_pc; n_ipc = m_inst_pc; n_inst = m_inst;
        if (rst) begin
            n_busy = 1'b0; n_stale = 1'b0; n_have = 1'b0;
            n_pc = RPC; n_ipc = 64'h0; n_inst = 32'h0;
            mem_pending = 1'b0;
        end else begin
            if (m_have && inst_ready) begin
                n_have = 1'b0;
                n_pc = m_pc + 64'd4;
            end
            if (m_busy && imem_rsp_valid) begin
                n_busy = 1'b0;
                n_stale = 1'b0;
                if (!m_stale && !redirect_valid) begin
                    n_have = 1'b1;
                    n_inst = imem_rsp_data;
                    n_ipc = m_pc;
                end
            end else if (m_busy && redirect_valid) begin
                n_stale = 1'b1;
            end
            if (hs) begin
                n_busy = 1'b1;
                n_stale = redirect_valid;
            end
            if (redirect_valid) begin
                n_pc = {redirect_pc[63:2], 2'b00};
                n_have = 1'b0;
            end
            if (mem_pending) begin
                if (mem_cnt == 0) mem_pending = 1'b0;
                else mem_cnt--;
            end
            if (hs) begin
                mem_pending = 1'b1;
                mem_addr = m_pc;
                mem_cnt = $urandom_range(0, mem_lat_max - 1);
            end
        end
        @(posedge clk);
        #1;
        m_busy = n_busy; m_stale = n_stale; m_have = n_have;
        m_pc = n_pc; m_inst_pc = n_ipc; m_inst = n_inst;
        exp_rv = !rst && !m_busy && !m_have;
        n_total++;
        if (imem_req_valid !== exp_rv)
            $display("FAIL model_req_valid t=%0t got=%b exp=%b", $time, imem_req_valid, exp_rv);
        else n_pass++;
        if (exp_rv) begin
            n_total++;
            if (imem_req_addr !== m_pc)
                $display("FAIL model_req_addr t=%0t got=%h exp=%h", $time, imem_req_addr, m_pc);
            else n_pass++;
        end
        n_total++;
        if (inst_valid !== m_have)
            $display("FAIL model_inst_valid t=%0t got=%b exp=%b", $time, inst_valid, m_have);
        else n_pass++;
        if (m_have) begin
            n_total++;
            if (inst !== m_inst || inst_pc !== m_inst_pc)
                $display("FAIL model_inst t=%0t got=%h@%h exp=%h@%h", $time, inst, inst_pc, m_inst, m_inst_pc);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        n_total++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 64'h0 || imem_req_valid !== 1'b0)
            $display("FAIL reset_state got v=%b i=%h pc=%h rv=%b exp 0/0/0/0", inst_valid, inst, inst_pc, imem_req_valid);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC)
            $display("FAIL reset_first_req got v=%b a=%h exp 1/%h", imem_req_valid, imem_req_addr, RPC);
        else n_pass++;
    endtask

    task automatic test_first_fetch();
        imem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat_max = 1;
        cycle();
        cycle();
        n_total++;
        if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== RPC)
            $display("FAIL first_fetch got v=%b i=%h pc=%h exp 1/00500093/%h", inst_valid, inst, inst_pc, RPC);
        else n_pass++;
    endtask

    task automatic test_decode_stall();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_total++;
            if (inst !== 32'h0050_0093 || inst_pc !== RPC || imem_req_valid !== 1'b0)
                $display("FAIL decode_stall got i=%h pc=%h rv=%b exp 00500093/%h/0", inst, inst_pc, imem_req_valid, RPC);
            else n_pass++;
        end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        n_total++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 64'd4)
            $display("FAIL decode_release got v=%b rv=%b a=%h exp 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, RPC + 64'd4);
        else n_pass++;
    endtask

    task automatic test_req_backpressure();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 64'd4 || inst_valid !== 1'b0)
                $display("FAIL req_hold got rv=%b a=%h v=%b exp 1/%h/0", imem_req_valid, imem_req_addr, inst_valid, RPC + 64'd4);
            else n_pass++;
        end
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        n_total++;
        if (inst_valid !== 1'b1 || inst_pc !== RPC + 64'd4 || inst !== mem_word(RPC + 64'd4))
            $display("FAIL req_resume got v=%b pc=%h i=%h exp 1/%h/%h", inst_valid, inst_pc, inst, RPC + 64'd4, mem_word(RPC + 64'd4));
        else n_pass++;
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0100;
        cycle();
        redirect_valid = 1'b0;
        n_total++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100)
            $display("FAIL redirect_wait got v=%b rv=%b a=%h exp 0/1/80000100", inst_valid, imem_req_valid, imem_req_addr);
        else n_pass++;
        cycle();
        cycle();
        n_total++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0100)
            $display("FAIL redirect_wait_fetch got v=%b pc=%h exp 1/80000100", inst_valid, inst_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_out();
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0203; inst_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        n_total++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200)
            $display("FAIL redirect_out got v=%b rv=%b a=%h exp 0/1/80000200", inst_valid, imem_req_valid, imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        cycle();
        rst = 1'b1;
        cycle();
        n_total++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL reset_mid got v=%b rv=%b exp 0/0", inst_valid, imem_req_valid);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC)
            $display("FAIL reset_mid_req got rv=%b a=%h exp 1/%h", imem_req_valid, imem_req_addr, RPC);
        else n_pass++;
    endtask

    task automatic test_wrap();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        n_total++;
        if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL wrap_redirect got a=%h exp fffffffffffffffc", imem_req_addr);
        else n_pass++;
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        n_total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
            $display("FAIL wrap_pc got rv=%b a=%h exp 1/0", imem_req_valid, imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        spurious = 1'b1; mem_lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = $urandom_range(0, 1);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? {62'h3FFF_FFFF_FFFF_FFFF, 2'(i)}
                                                         : {32'h0, $urandom};
            rst            = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; redirect_valid = 1'b0; spurious = 1'b0; mem_lat_max = 1;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0;
        m_busy = 1'b0; m_stale = 1'b0; m_have = 1'b0;
        m_pc = RPC; m_inst_pc = 64'h0; m_inst = 32'h0;
        mem_pending = 1'b0; mem_cnt = 0; mem_addr = 64'h0;
        #1;
        test_reset();
        test_first_fetch();
        test_decode_stall();
        test_req_backpressure();
        test_redirect_wait();
        test_redirect_out();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
